smi_flit_scale_stage_d2: RTL and testbench
==========================================

# smi_flit_scale_stage_d2

Single SMI flit width reduction stage: accepts flits of 2*FlitWidth bytes and emits them as FlitWidth-byte flits, low half first, preserving frame boundaries and end-of-frame byte counts. It is the downsizing counterpart of the X2 expansion stage. Chains of these stages sit on the egress side of the wide fabric datapath, feeding narrow SMI consumers. Stages cascade directly, the output of one stage driving the input of the next.

## Interface
- FlitWidth, 4: output flit width in bytes, a power of two, 1..64. The input flit is 2*FlitWidth bytes.
- EofcMask, 4*FlitWidth-1: mask applied to the input eofc. Derived; do not override.

- clk  input  1  clock; all state updates on the rising edge.
- arst_n  input  1  reset, asynchronous and active-low.
- smiInReady  input  1  input flit valid.
- smiInEofc  input  8  input end-of-frame control. 0 means not last; N in 1..2*FlitWidth means last flit with N valid bytes.
- smiInData  input  FlitWidth*16  input flit. Byte 0 is in bits [7:0].
- smiInStop  output  1  input backpressure.
- smiOutReady  output  1  output flit valid.
- smiOutEofc  output  8  output end-of-frame control. 0 or 1..FlitWidth.
- smiOutData  output  FlitWidth*8  output flit.
- smiOutStop  input  1  output backpressure.

## Operation
- Handshake on both ports: a flit transfers on a rising edge where Ready=1 and Stop=0. The source holds Ready, Eofc and Data stable while Stop=1.
- Input register holds: in_full, in_data, in_eofc (masked by EofcMask), in_last (eofc != 0), and phase (0 = low half pending, 1 = high half pending).
- Output register holds: smiOutReady, smiOutEofc, smiOutData.
- out_load = ~(smiOutReady & smiOutStop).
- Half selection, evaluated when in_full:
  - Phase 0: data is in_data low half. If in_last and in_eofc <= FlitWidth, the flit is short-last: eofc = in_eofc and done = 1. Otherwise eofc = 0 and done = 0.
  - Phase 1: data is in_data high half. Eofc = in_last ? in_eofc - FlitWidth : 0. done = 1.
- On out_load with in_full:
  - Load the output register with the selected half and set smiOutReady = 1.
  - If done, set phase to 0 and free the input register; otherwise set phase to 1.
- On out_load with ~in_full: smiOutReady <= 0.
- smiInStop = in_full & ~(out_load & done). This is combinational.
- When the input register is freed, or is empty, it loads smiInReady/smiInData/smiInEofc in the same edge. A freed register is therefore refilled with no bubble.
- Eofc values above 2*FlitWidth after masking are out of contract. The block does not check them; verification excludes them.
- Reset (arst_n=0) immediately clears in_full, phase, smiOutReady and smiOutEofc. Data registers are not reset.
- A reset mid-frame discards any partial frame; upstream is reset with the same signal.

## Timing
- Reset values: smiOutReady=0, smiOutEofc=0, smiInStop=0. smiOutData is don't-care while smiOutReady=0.
- Latency: a flit accepted at edge N presents its low half after edge N+1. Its high half follows after edge N+2 if smiOutStop=0.
- Throughput:
  - Output runs at one narrow flit per cycle.
  - Input runs at one wide flit per 2 cycles, except short-last flits at one per cycle.
  - With non-last flits streaming, smiInStop alternates 1 (phase 0), 0 (phase 1).
- smiOutStop=1 while smiOutReady=1 holds all state and outputs, and forces smiInStop=in_full.
- smiOutStop while smiOutReady=0 has no effect.
- Combinational paths: smiOutStop to smiInStop only. No path from smiInReady to any output.

## Test plan
All scenarios use FlitWidth=4 (64-bit input, 32-bit output).
- Reset: drive arst_n=0 between clock edges while the output is valid. Required: smiOutReady=0, smiOutEofc=0 and smiInStop=0 before the next edge. The output stays idle until new input arrives.
- Full frame: send 0x11111111_22222222 eofc 0, then 0x33333333_44444444 eofc 8, with smiOutStop=0. Required: 0x22222222/0, 0x11111111/0, 0x44444444/0, 0x33333333/4 on four consecutive cycles. smiInStop is 1 on the cycles when phase is 0.
- Short last: send back-to-back single-flit frames 0x0000_0000_AAAABBBB eofc 3 and 0x0000_0000_CCCCDDDD eofc 4. Required: 0xAAAABBBB/3, then 0xCCCCDDDD/4 on the next cycle. smiInStop stays 0 throughout.
- Split last: send 0x55555555_66666666 eofc 5. Required: 0x66666666/0, then 0x55555555/1.
- Backpressure: hold smiOutStop=1 for 3 cycles while the high half of a non-last flit is presented. Required: smiOutData, smiOutEofc and smiOutReady stay stable, and smiInStop=1. On release, the stream resumes with no lost or duplicated flit.
- Soak: run a random-length frame stream with random smiInReady and smiOutStop. Required: the output byte stream and frame lengths match the reference model exactly.

Source files
------------

// File: rtl/smi_flit_scale_stage_d2.sv
// SMI flit width reduction stage: splits each 2*FlitWidth-byte flit into two
// FlitWidth-byte flits, low half first, keeping frame ends and byte counts intact.
module smi_flit_scale_stage_d2 #(
    parameter int FlitWidth = 4,
    parameter int EofcMask  = 4 * FlitWidth - 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     smiInReady,
    input  logic [7:0]               smiInEofc,
    input  logic [FlitWidth*16-1:0]  smiInData,
    output logic                     smiInStop,
    output logic                     smiOutReady,
    output logic [7:0]               smiOutEofc,
    output logic [FlitWidth*8-1:0]   smiOutData,
    input  logic                     smiOutStop
);

    // state  | meaning
    // PH_LO  | low half of the held wide flit is next to go out
    // PH_HI  | low half already sent, high half is next
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

    localparam int          IW        = FlitWidth * 16;
    localparam int          OW        = FlitWidth * 8;
    localparam logic [7:0]  FW8       = 8'(FlitWidth);
    localparam logic [7:0]  EOFC_MASK = 8'(EofcMask);

    phase_e          phase_q, phase_d;
    logic            in_full_q, in_full_d;
    logic [IW-1:0]   in_data_q, in_data_d;
    logic [7:0]      in_eofc_q, in_eofc_d;
    logic            in_last_q, in_last_d;
    logic            out_ready_q, out_ready_d;
    logic [7:0]      out_eofc_q, out_eofc_d;
    logic [OW-1:0]   out_data_q, out_data_d;

    logic [OW-1:0]   sel_data;
    logic [7:0]      sel_eofc;
    logic            sel_done;
    logic            out_load;
    logic            take_half;
    logic            in_load;
    logic [7:0]      in_eofc_masked;

    assign in_eofc_masked = smiInEofc & EOFC_MASK;

    // A last flit that fits in the low half finishes in one output beat.
    always_comb begin
        sel_data = in_data_q[OW-1:0];
        sel_eofc = '0;
        sel_done = 1'b0;
        if (phase_q == PH_HI) begin
            sel_data = in_data_q[IW-1:OW];
            sel_eofc = in_last_q ? (in_eofc_q - FW8) : 8'd0;
            sel_done = 1'b1;
        end else if (in_last_q && (in_eofc_q <= FW8)) begin
            sel_eofc = in_eofc_q;
            sel_done = 1'b1;
        end
    end

    assign out_load  = ~(out_ready_q & smiOutStop);
    assign take_half = out_load & in_full_q;
    assign in_load   = ~in_full_q | (take_half & sel_done);
    assign smiInStop = in_full_q & ~(out_load & sel_done);

    always_comb begin
        phase_d     = phase_q;
        in_full_d   = in_full_q;
        in_data_d   = in_data_q;
        in_eofc_d   = in_eofc_q;
        in_last_d   = in_last_q;
        out_ready_d = out_ready_q;
        out_eofc_d  = out_eofc_q;
        out_data_d  = out_data_q;

        if (take_half) begin
            out_ready_d = 1'b1;
            out_data_d  = sel_data;
            out_eofc_d  = sel_eofc;
            phase_d     = sel_done ? PH_LO : PH_HI;
        end else if (out_load) begin
            out_ready_d = 1'b0;
        end

        // Refill in the same edge the register frees up, so no bubble.
        if (in_load) begin
            in_full_d = smiInReady;
            if (smiInReady) begin
                in_data_d = smiInData;
                in_eofc_d = in_eofc_masked;
                in_last_d = (in_eofc_masked != 8'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            phase_q     <= PH_LO;
            in_full_q   <= 1'b0;
            out_ready_q <= 1'b0;
            out_eofc_q  <= 8'd0;
        end else begin
            phase_q     <= phase_d;
            in_full_q   <= in_full_d;
            out_ready_q <= out_ready_d;
            out_eofc_q  <= out_eofc_d;
        end
    end

    // Payload registers carry no reset; they are qualified by the valid flags.
    always_ff @(posedge clk) begin
        in_data_q  <= in_data_d;
        in_eofc_q  <= in_eofc_d;
        in_last_q  <= in_last_d;
        out_data_q <= out_data_d;
    end

    assign smiOutReady = out_ready_q;
    assign smiOutEofc  = out_eofc_q;
    assign smiOutData  = out_data_q;

endmodule

// File: tb/tb_smi_flit_scale_stage_d2.sv
// Bench for smi_flit_scale_stage_d2 (FlitWidth=4): directed scenarios plus a
// random soak, checked against a half-splitting queue model.
module tb_smi_flit_scale_stage_d2;

    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        smiInReady = 1'b0;
    logic [7:0]  smiInEofc = 8'd0;
    logic [63:0] smiInData = 64'd0;
    logic        smiInStop;
    logic        smiOutReady;
    logic [7:0]  smiOutEofc;
    logic [31:0] smiOutData;
    logic        smiOutStop = 1'b0;

    smi_flit_scale_stage_d2 #(.FlitWidth(FW)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .smiInReady (smiInReady),
        .smiInEofc  (smiInEofc),
        .smiInData  (smiInData),
        .smiInStop  (smiInStop),
        .smiOutReady(smiOutReady),
        .smiOutEofc (smiOutEofc),
        .smiOutData (smiOutData),
        .smiOutStop (smiOutStop)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_stalls = 0;
    bit          soak_on = 1'b0;
    logic [39:0] exp_q[$];
    logic [39:0] log_q[$];
    int          log_cyc[$];
    logic [39:0] want_q[$];
    logic        prev_hold = 1'b0;
    logic [39:0] prev_out = 40'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: a wide flit becomes one narrow flit if it is a last flit holding
    // at most FW bytes, otherwise two; the last byte count moves with the tail.
    function automatic void model_accept(input logic [63:0] d, input logic [7:0] e);
        if (e != 8'd0 && e <= 8'(FW)) begin
            exp_q.push_back({e, d[31:0]});
        end else begin
            exp_q.push_back({8'd0, d[31:0]});
            exp_q.push_back({(e != 8'd0) ? e - 8'(FW) : 8'd0, d[63:32]});
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!arst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_ready", 64'(smiOutReady), 64'd1);
                chk("hold_flit", 64'({smiOutEofc, smiOutData}), 64'(prev_out));
            end
            if (smiOutReady && !smiOutStop) begin
                log_q.push_back({smiOutEofc, smiOutData});
                log_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want none", {smiOutEofc, smiOutData});
                end else begin
                    chk("out_flit", 64'({smiOutEofc, smiOutData}), 64'(exp_q.pop_front()));
                end
            end
            if (smiInReady && !smiInStop) model_accept(smiInData, smiInEofc);
            prev_hold = smiOutReady && smiOutStop;
            prev_out  = {smiOutEofc, smiOutData};
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] e);
        int n = 0;
        smiInReady = 1'b1;
        smiInData  = d;
        smiInEofc  = e;
        @(negedge clk);
        while (smiInStop && n < 200) begin
            n++;
            @(negedge clk);
        end
        last_stalls = n;
        if (smiInStop) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got stalled want accepted");
        end
        @(posedge clk);
        #1;
        smiInReady = 1'b0;
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
        want_q.delete();
    endtask

    task automatic check_log(input string name, input bit consecutive);
        chk({name, "_count"}, 64'(log_q.size()), 64'(want_q.size()));
        for (int i = 0; i < want_q.size() && i < log_q.size(); i++) begin
            chk({name, "_flit"}, 64'(log_q[i]), 64'(want_q[i]));
            if (consecutive) chk({name, "_cycle"}, 64'(log_cyc[i] - log_cyc[0]), 64'(i));
        end
    endtask

    initial begin
        int n;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(smiOutReady), 64'd0);
        chk("rst_eofc", 64'(smiOutEofc), 64'd0);
        chk("rst_instop", 64'(smiInStop), 64'd0);
        arst_n = 1'b1;
        idle(1);

        // full two-flit frame
        clear_log();
        send(64'h11111111_22222222, 8'd0);
        chk("ff_stall_a", 64'(last_stalls), 64'd0);
        send(64'h33333333_44444444, 8'd8);
        chk("ff_stall_b", 64'(last_stalls), 64'd1);
        idle(6);
        want_q = '{40'h00_22222222, 40'h00_11111111, 40'h00_44444444, 40'h04_33333333};
        check_log("full", 1'b1);

        // back-to-back short last flits
        clear_log();
        send(64'h00000000_AAAABBBB, 8'd3);
        chk("sl_stall_a", 64'(last_stalls), 64'd0);
        send(64'h00000000_CCCCDDDD, 8'd4);
        chk("sl_stall_b", 64'(last_stalls), 64'd0);
        @(negedge clk);
        chk("sl_instop", 64'(smiInStop), 64'd0);
        idle(5);
        want_q = '{40'h03_AAAABBBB, 40'h04_CCCCDDDD};
        check_log("short", 1'b1);

        // last flit split across both halves
        clear_log();
        send(64'h55555555_66666666, 8'd5);
        idle(5);
        want_q = '{40'h00_66666666, 40'h01_55555555};
        check_log("split", 1'b1);

        // backpressure on the high half of a non-last flit
        clear_log();
        send(64'h77777777_88888888, 8'd0);
        fork
            send(64'h99999999_AAAAAAAA, 8'd8);
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                smiOutStop = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ready", 64'(smiOutReady), 64'd1);
                    chk("bp_data", 64'(smiOutData), 64'h77777777);
                    chk("bp_eofc", 64'(smiOutEofc), 64'd0);
                    chk("bp_instop", 64'(smiInStop), 64'd1);
                end
                @(posedge clk);
                #1;
                smiOutStop = 1'b0;
            end
        join
        idle(6);
        want_q = '{40'h00_88888888, 40'h00_77777777, 40'h00_AAAAAAAA, 40'h04_99999999};
        check_log("bp", 1'b0);

        // asynchronous reset while the output is valid
        send(64'hDEADBEEF_0BADF00D, 8'd0);
        @(posedge clk);
        #2;
        chk("ar_ready_before", 64'(smiOutReady), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("ar_ready", 64'(smiOutReady), 64'd0);
        chk("ar_eofc", 64'(smiOutEofc), 64'd0);
        chk("ar_instop", 64'(smiInStop), 64'd0);
        exp_q.delete();
        clear_log();
        #1;
        arst_n = 1'b1;
        idle(4);
        chk("ar_idle_count", 64'(log_q.size()), 64'd0);
        chk("ar_idle_ready", 64'(smiOutReady), 64'd0);
        clear_log();
        send(64'hBBBBBBBB_CCCCCCCC, 8'd2);
        idle(4);
        want_q = '{40'h02_CCCCCCCC};
        check_log("ar_recover", 1'b0);

        // random soak
        soak_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 60; f++) begin
                    int nf;
                    nf = $urandom_range(1, 4);
                    for (int k = 0; k < nf; k++) begin
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                        send({$urandom, $urandom}, (k == nf - 1) ? 8'($urandom_range(1, 8)) : 8'd0);
                    end
                end
                soak_on = 1'b0;
            end
            begin
                while (soak_on) begin
                    @(posedge clk);
                    #1;
                    smiOutStop = ($urandom_range(0, 2) == 0);
                end
                smiOutStop = 1'b0;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_ready", 64'(smiOutReady), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
